// File: rtl/nibble_serial_sub.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_sub
// Description : Computes d = a - b - bin over WIDTH bits, one 4-bit nibble
//               per clock (LSB nibble first) through a borrow-lookahead slice.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    // WIDTH must be a multiple of 4 and at least 4.
    localparam int c_NIBBLES = WIDTH / 4;
    localparam int c_KW      = (c_NIBBLES > 1) ? $clog2(c_NIBBLES) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_d;
    logic [c_KW-1:0]  r_k;
    logic             r_borrow;
    logic             r_bout;
    logic             r_ovf;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic [4:0]       w_c;
    logic [3:0]       w_dif;
    logic             w_last;

    always_comb begin
        w_a_nib = r_a[3:0];
        w_b_nib = r_b[3:0];
        for (int n = 0; n < c_NIBBLES; n++) begin
            if (r_k == c_KW'(n)) begin
                w_a_nib = r_a[4*n +: 4];
                w_b_nib = r_b[4*n +: 4];
            end
        end
    end

    assign w_last = (r_k == c_KW'(c_NIBBLES - 1));

    // Borrow generate/propagate; every borrow is a flat sum of products.
    assign w_g = ~w_a_nib & w_b_nib;
    assign w_p = ~(w_a_nib ^ w_b_nib);

    assign w_c[0] = r_borrow;
    assign w_c[1] = w_g[0] | (w_p[0] & r_borrow);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_borrow);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & r_borrow);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_borrow);

    assign w_dif = w_a_nib ^ w_b_nib ^ w_c[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_k      <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_k      <= '0;
                        r_d      <= '0;
                        r_bout   <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_state  <= c_RUN;
                    end
                end
                c_RUN: begin
                    for (int n = 0; n < c_NIBBLES; n++) begin
                        if (r_k == c_KW'(n)) begin
                            r_d[4*n +: 4] <= w_dif;
                        end
                    end
                    r_borrow <= w_c[4];
                    r_k      <= r_k + 1'b1;
                    if (w_last) begin
                        // Top nibble's bit 3 is the result sign bit.
                        r_bout  <= w_c[4];
                        r_ovf   <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &
                                   (w_dif[3] != r_a[WIDTH-1]);
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign d         = r_d;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_sub
// Description : Directed and random checks of nibble_serial_sub (WIDTH 16, 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_sub;

    logic        clk = 1'b0;
    logic        rst;

    logic        iv16, ir16, ov16, or16, bin16, bout16, ovf16;
    logic [15:0] a16, b16, d16;
    logic        iv4, ir4, ov4, or4, bin4, bout4, ovf4;
    logic [3:0]  a4, b4, d4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nibble_serial_sub #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .bin(bin16), .out_valid(ov16), .out_ready(or16),
        .d(d16), .bout(bout16), .ovf(ovf16)
    );

    nibble_serial_sub #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .bin(bin4), .out_valid(ov4), .out_ready(or4),
        .d(d4), .bout(bout4), .ovf(ovf4)
    );

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", tag, what, obs, exp);
        end
    endtask

    // Reference: true integer difference, then wrap / sign-range tests.
    function automatic void model(input int w, input int ua, input int ub, input int ubin,
                                  output int ed, output int eb, output int eo);
        int half = 1 << (w - 1);
        int r    = ua - ub - ubin;
        int sa   = (ua >= half) ? ua - 2 * half : ua;
        int sb   = (ub >= half) ? ub - 2 * half : ub;
        int sr   = sa - sb - ubin;
        ed = r & ((1 << w) - 1);
        eb = (r < 0) ? 1 : 0;
        eo = (sr < -half || sr >= half) ? 1 : 0;
    endfunction

    task automatic run16(input string tag, input logic [15:0] ua, input logic [15:0] ub,
                         input logic ubin, input int hold);
        int ed, eb, eo, cyc;
        logic [15:0] d_snap;
        model(16, int'(ua), int'(ub), int'(ubin), ed, eb, eo);
        a16 = ua; b16 = ub; bin16 = ubin; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
        check(tag, "in_ready_busy", ir16, 0);
        cyc = 0;
        while (!ov16 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check(tag, "latency", cyc, 4);
        check(tag, "d", d16, ed);
        check(tag, "bout", bout16, eb);
        check(tag, "ovf", ovf16, eo);
        d_snap = d16;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        if (hold > 0) begin
            check(tag, "hold_valid", ov16, 1);
            check(tag, "hold_d", d16, d_snap);
        end
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        check(tag, "post_valid", ov16, 0);
        check(tag, "post_ready", ir16, 1);
    endtask

    task automatic run4(input string tag, input logic [3:0] ua, input logic [3:0] ub,
                        input logic ubin);
        int ed, eb, eo, cyc;
        model(4, int'(ua), int'(ub), int'(ubin), ed, eb, eo);
        a4 = ua; b4 = ub; bin4 = ubin; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        cyc = 0;
        while (!ov4 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check(tag, "latency", cyc, 1);
        check(tag, "d", d4, ed);
        check(tag, "bout", bout4, eb);
        check(tag, "ovf", ovf4, eo);
        or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0;
        check(tag, "post_ready", ir4, 1);
    endtask

    initial begin
        int cyc;
        logic [15:0] d_snap;
        logic        b_snap, o_snap;

        rst = 1'b1;
        iv16 = 0; or16 = 0; a16 = 0; b16 = 0; bin16 = 0;
        iv4 = 0; or4 = 0; a4 = 0; b4 = 0; bin4 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", "in_ready", ir16, 1);
        check("reset", "out_valid", ov16, 0);
        check("reset", "d", d16, 0);
        check("reset", "bout", bout16, 0);
        check("reset", "ovf", ovf16, 0);
        check("reset", "in_ready4", ir4, 1);
        rst = 1'b0;

        run16("basic", 16'h1234, 16'h0234, 1'b0, 0);
        run16("underflow", 16'h0000, 16'h0001, 1'b0, 0);
        run16("eq_bin", 16'h0005, 16'h0005, 1'b1, 0);
        run16("ovf_neg", 16'h8000, 16'h0001, 1'b0, 0);
        run16("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 0);

        // Backpressure: result held, new request refused while in DONE.
        a16 = 16'h1111; b16 = 16'h0222; bin16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;
        a16 = 16'h5555; b16 = 16'h1234;
        cyc = 0;
        while (!ov16 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp", "d", d16, 16'h0EEF);
        d_snap = d16; b_snap = bout16; o_snap = ovf16;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp", "hold_valid", ov16, 1);
            check("bp", "hold_d", d16, d_snap);
            check("bp", "hold_bout", bout16, b_snap);
            check("bp", "hold_ovf", ovf16, o_snap);
            check("bp", "hold_ready", ir16, 0);
        end
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        check("bp", "released_valid", ov16, 0);
        check("bp", "released_ready", ir16, 1);
        @(posedge clk); #1;
        iv16 = 1'b0;
        check("bp", "accepted", ir16, 0);
        cyc = 0;
        while (!ov16 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp", "next_latency", cyc, 4);
        check("bp", "next_d", d16, 16'h4321);
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;

        // Reset while k == 2.
        a16 = 16'hFFFF; b16 = 16'h0001; bin16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst", "out_valid", ov16, 0);
        check("midrst", "in_ready", ir16, 1);
        check("midrst", "d", d16, 0);
        run16("after_rst", 16'hABCD, 16'h1111, 1'b0, 0);

        for (int i = 0; i < 30; i++) begin
            run16("rand16", 16'($urandom), 16'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)));
        end

        run4("w4_basic", 4'h3, 4'h5, 1'b0);
        for (int i = 0; i < 20; i++) begin
            run4("rand4", 4'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
